// File: rtl/mem_responder_if.sv
// Word-level memory port shared by the rv32i multicycle core and its memory.
// master = requester (CPU/bench), slave = memory responder.
interface mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable,
    output mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable,
    input  mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory behind the multicycle core's memory port.
// Optional MEM_PROTOCOL_CHECK_EN adds a sticky protocol_err monitor.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic clk,
  input  logic rst_n,
  mem_if.slave bus,
  output logic proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int          WORDS    = 2 ** ADDR_BITS;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [WORDS];

  logic        req;
  logic        commit;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic [ADDR_BITS-1:0] idx;
  logic        unused_addr_bits;

  assign req = bus.mem_read | bus.mem_write;

  // Live inputs only matter on the IDLE->RESP shortcut (LATENCY=1).
  always_comb begin
    sel_wr    = wr_q;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    sel_be    = be_q;
    if (state_q == IDLE) begin
      sel_wr    = bus.mem_write;
      sel_addr  = bus.mem_address;
      sel_wdata = bus.mem_wdata;
      sel_be    = bus.mem_byte_enable;
    end
  end

  assign idx = sel_addr[ADDR_BITS+1:2];
  assign unused_addr_bits =
    ^{sel_addr[31:ADDR_BITS+2], sel_addr[1:0]};

  // Next state; commit marks the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && !sel_wr)
        rdata_q <= mem_q[idx];
    end
  end

  // Request capture on acceptance in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (state_q == IDLE && req) begin
      wr_q    <= bus.mem_write;
      addr_q  <= bus.mem_address;
      wdata_q <= bus.mem_wdata;
      be_q    <= bus.mem_byte_enable;
    end
  end

  // Storage keeps contents over reset; rst_n gates an aborted commit.
  always_ff @(posedge clk) begin
    if (rst_n && commit && sel_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_be[i])
          mem_q[idx][8*i +: 8] <= sel_wdata[8*i +: 8];
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = (state_q == RESP);

`ifdef MEM_PROTOCOL_CHECK_EN
  logic err_q;
  logic viol;

  // Dual op in IDLE, or request not held stable while BUSY.
  always_comb begin
    viol = 1'b0;
    if (state_q == IDLE && bus.mem_read && bus.mem_write)
      viol = 1'b1;
    if (state_q == BUSY &&
        (!req || bus.mem_address != addr_q ||
         bus.mem_write != wr_q))
      viol = 1'b1;
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | viol;
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Random + directed bench for mem_responder (LATENCY=3 and LATENCY=1).
// Reference memory is a sparse word map updated per completed write.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_if ia ();
  mem_if ib ();
  logic perr_a, perr_b;

  mem_responder #(.ADDR_BITS(10), .LATENCY(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave), .proto_err(perr_a)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave), .proto_err(perr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = 32'd0;
  logic [31:0] rd;
  logic        exp_perr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_a();
    ia.mem_read = 1'b0;
    ia.mem_write = 1'b0;
    ia.mem_byte_enable = 4'h0;
    ia.mem_address = 32'h0;
    ia.mem_wdata = 32'h0;
  endtask

  task automatic idle_b();
    ib.mem_read = 1'b0;
    ib.mem_write = 1'b0;
    ib.mem_byte_enable = 4'h0;
    ib.mem_address = 32'h0;
    ib.mem_wdata = 32'h0;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One transaction on the LATENCY=3 port; starts in cycle 0 (#1 after edge).
  task automatic xfer_a(input string tag, input bit r, input bit w,
                        input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd,
                        output logic [31:0] rdata);
    int got;
    int k;
    logic [31:0] exp;
    got = 0;
    rdata = 32'hx;
    k = widx(addr);
    exp = ref_mem.exists(k) ? ref_mem[k] : 32'hx;
    ia.mem_read = r;
    ia.mem_write = w;
    ia.mem_byte_enable = be;
    ia.mem_address = addr;
    ia.mem_wdata = wd;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(posedge clk); #1;
      if (ia.mem_resp === 1'b1) begin
        got = c;
        rdata = ia.mem_rdata;
      end
    end
    idle_a();
    chk({tag, "_lat"}, 32'(got), 32'd3);
    if (w) begin
      chk({tag, "_rdhold"}, rdata, last_rd);
      ref_mem[k] = merge(ref_mem.exists(k) ? ref_mem[k] : 32'h0, wd, be);
    end else begin
      chk({tag, "_rdata"}, rdata, exp);
      last_rd = rdata;
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, ia.mem_resp}, 32'd0);
  endtask

  initial begin
    int pulses;
    int rv;
    int k;
    logic [31:0] a;
`ifdef MEM_PROTOCOL_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    idle_a();
    idle_b();
    #12;
    chk("rst_resp_a", {31'd0, ia.mem_resp}, 32'd0);
    chk("rst_rdata_a", ia.mem_rdata, 32'd0);
    chk("rst_perr_a", {31'd0, perr_a}, 32'd0);
    chk("rst_resp_b", {31'd0, ib.mem_resp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LATENCY=1: write held through RESP, drop, then a read.
    pulses = 0;
    ib.mem_write = 1'b1;
    ib.mem_byte_enable = 4'hF;
    ib.mem_address = 32'h8;
    ib.mem_wdata = 32'h1357_9BDF;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("b_resp_c%0d", c), {31'd0, ib.mem_resp},
          (c == 1 || c == 4) ? 32'd1 : 32'd0);
      if (ib.mem_resp === 1'b1) pulses++;
      if (c == 4) chk("b_rdata", ib.mem_rdata, 32'h1357_9BDF);
      if (c == 2 || c == 5) idle_b();
      if (c == 3) begin
        ib.mem_read = 1'b1;
        ib.mem_address = 32'h8;
      end
    end
    chk("b_pulses", 32'(pulses), 32'd2);

    // Basic write/read.
    xfer_a("t1_wr", 0, 1, 4'hF, 32'h40, 32'hDEAD_BEEF, rd);
    xfer_a("t1_rd", 1, 0, 4'h0, 32'h40, 32'h0, rd);

    // Byte lanes.
    xfer_a("t2_pre", 0, 1, 4'hF, 32'h80, 32'h1122_3344, rd);
    xfer_a("t2_wr", 0, 1, 4'h5, 32'h80, 32'hAABB_CCDD, rd);
    xfer_a("t2_rd", 1, 0, 4'h0, 32'h80, 32'h0, rd);
    chk("t2_val", rd, 32'h11BB_33DD);

    // Index wrap and misaligned address.
    xfer_a("t5_wr", 0, 1, 4'hF, 32'h1004, 32'h5A5A_5A5A, rd);
    xfer_a("t5_rd", 1, 0, 4'h0, 32'h0004, 32'h0, rd);
    chk("t5_val", rd, 32'h5A5A_5A5A);
    xfer_a("t5_mis", 1, 0, 4'h0, 32'h0006, 32'h0, rd);

    // Zero byte enables: responds, no change.
    xfer_a("be0_wr", 0, 1, 4'h0, 32'h40, 32'h0BAD_0BAD, rd);
    xfer_a("be0_rd", 1, 0, 4'h0, 32'h40, 32'h0, rd);
    chk("be0_val", rd, 32'hDEAD_BEEF);
    chk("perr_clean", {31'd0, perr_a}, 32'd0);

    // Read and write together: write wins.
    xfer_a("both", 1, 1, 4'hF, 32'h200, 32'hCAFE_F00D, rd);
    xfer_a("both_rd", 1, 0, 4'h0, 32'h200, 32'h0, rd);
    chk("both_perr", {31'd0, perr_a}, {31'd0, exp_perr});

    // Inputs changing while BUSY are ignored.
    xfer_a("chg_pre", 0, 1, 4'hF, 32'h204, 32'h7777_7777, rd);
    ia.mem_write = 1'b1;
    ia.mem_byte_enable = 4'hF;
    ia.mem_address = 32'h200;
    ia.mem_wdata = 32'h0123_4567;
    @(posedge clk); #1;
    ia.mem_address = 32'h204;
    ia.mem_wdata = 32'h0;
    ia.mem_byte_enable = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("chg_resp", {31'd0, ia.mem_resp}, 32'd1);
    idle_a();
    ref_mem[widx(32'h200)] = 32'h0123_4567;
    @(posedge clk); #1;
    xfer_a("chg_rd0", 1, 0, 4'h0, 32'h200, 32'h0, rd);
    xfer_a("chg_rd1", 1, 0, 4'h0, 32'h204, 32'h0, rd);
    chk("chg_perr", {31'd0, perr_a}, {31'd0, exp_perr});

    // Reset during BUSY aborts the write.
    xfer_a("rst_pre", 0, 1, 4'hF, 32'h100, 32'h0, rd);
    ia.mem_write = 1'b1;
    ia.mem_byte_enable = 4'hF;
    ia.mem_address = 32'h100;
    ia.mem_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_resp", {31'd0, ia.mem_resp}, 32'd0);
    chk("rst_mid_rdata", ia.mem_rdata, 32'd0);
    chk("rst_mid_perr", {31'd0, perr_a}, 32'd0);
    idle_a();
    last_rd = 32'd0;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      chk("rst_hold_resp", {31'd0, ia.mem_resp}, 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer_a("rst_rd", 1, 0, 4'h0, 32'h100, 32'h0, rd);
    chk("rst_val", rd, 32'h0);

    // Random traffic over 16 words, addresses carry wrap/low garbage.
    for (int i = 0; i < 16; i++)
      xfer_a("rnd_pre", 0, 1, 4'hF, 32'(i << 2), $urandom, rd);
    for (int n = 0; n < 150; n++) begin
      rv = $urandom;
      k = $urandom_range(0, 15);
      a = (32'(rv) & 32'hFFFF_F003) | 32'(k << 2);
      if ($urandom_range(0, 1) == 1)
        xfer_a($sformatf("rnd_wr%0d", n), 0, 1,
               4'($urandom_range(0, 15)), a, $urandom, rd);
      else
        xfer_a($sformatf("rnd_rd%0d", n), 1, 0, 4'h0, a, 32'h0, rd);
    end
    chk("perr_b", {31'd0, perr_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
